// File: rtl/fp_to_int_pipe.sv
// Three-stage IEEE-754 single to signed 32-bit integer converter (truncate toward zero)
// with saturation, inexact flag, valid/ready flow control and a saturating overflow counter.
module fp_to_int_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ovf,
  output logic             out_inexact,
  output logic [CNT_W-1:0] ovf_count
);

  logic adv;

  logic        s1_valid_q;
  logic        s1_sign_q;
  logic [7:0]  s1_exp_q;
  logic [23:0] s1_mant_q;

  logic        s2_valid_q;
  logic        s2_sign_q;
  logic        s2_ovf_q;
  logic        s2_inexact_q;
  logic [31:0] s2_mag_q;

  logic        s2_sign_d;
  logic        s2_ovf_d;
  logic        s2_inexact_d;
  logic [31:0] s2_mag_d;
  logic [7:0]  rshift;
  logic [23:0] low_mask;

  logic        out_valid_q;
  logic        out_ovf_q;
  logic        out_inexact_q;
  logic [31:0] out_data_q;
  logic [31:0] out_data_d;
  logic        out_inexact_d;

  logic [CNT_W-1:0] ovf_count_q;

  // The whole pipeline moves as one unit whenever the output slot is free or draining.
  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;

  always_comb begin
    s2_sign_d    = s1_sign_q;
    s2_ovf_d     = 1'b0;
    s2_inexact_d = 1'b0;
    s2_mag_d     = '0;
    rshift       = 8'd150 - s1_exp_q;
    low_mask     = ~(24'hFFFFFF << rshift);
    if (s1_exp_q == 8'd255) begin
      // NaN saturates positive whatever its sign bit says.
      s2_ovf_d = 1'b1;
      if (s1_mant_q[22:0] != 23'd0) s2_sign_d = 1'b0;
    end else if (s1_exp_q >= 8'd158) begin
      if (s1_sign_q && (s1_exp_q == 8'd158) && (s1_mant_q[22:0] == 23'd0))
        s2_mag_d = 32'h8000_0000;
      else
        s2_ovf_d = 1'b1;
    end else if (s1_exp_q >= 8'd151) begin
      s2_mag_d = {8'd0, s1_mant_q} << (s1_exp_q - 8'd150);
    end else if (s1_exp_q >= 8'd127) begin
      s2_mag_d     = {8'd0, s1_mant_q} >> rshift;
      s2_inexact_d = (s1_mant_q & low_mask) != 24'd0;
    end else begin
      s2_inexact_d = s1_mant_q != 24'd0;
    end
  end

  always_comb begin
    out_inexact_d = s2_inexact_q & ~s2_ovf_q;
    if (s2_ovf_q)
      out_data_d = s2_sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      out_data_d = s2_sign_q ? (32'd0 - s2_mag_q) : s2_mag_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_exp_q      <= '0;
      s1_mant_q     <= '0;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_ovf_q      <= 1'b0;
      s2_inexact_q  <= 1'b0;
      s2_mag_q      <= '0;
      out_valid_q   <= 1'b0;
      out_ovf_q     <= 1'b0;
      out_inexact_q <= 1'b0;
      out_data_q    <= '0;
    end else if (adv) begin
      s1_valid_q    <= in_valid;
      s1_sign_q     <= in_data[31];
      s1_exp_q      <= in_data[30:23];
      s1_mant_q     <= (in_data[30:23] == 8'd0) ? 24'd0 : {1'b1, in_data[22:0]};
      s2_valid_q    <= s1_valid_q;
      s2_sign_q     <= s2_sign_d;
      s2_ovf_q      <= s2_ovf_d;
      s2_inexact_q  <= s2_inexact_d;
      s2_mag_q      <= s2_mag_d;
      out_valid_q   <= s2_valid_q;
      out_ovf_q     <= s2_ovf_q;
      out_inexact_q <= out_inexact_d;
      out_data_q    <= out_data_d;
    end
  end

  // Counts delivered overflow results only, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (reset)
      ovf_count_q <= '0;
    else if (out_valid_q && out_ready && out_ovf_q && !(&ovf_count_q))
      ovf_count_q <= ovf_count_q + 1'b1;
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_ovf     = out_ovf_q;
  assign out_inexact = out_inexact_q;
  assign ovf_count   = ovf_count_q;

endmodule
